// File: rtl/vec_mag_iter.sv
// Iterative vector magnitude: floor (or rounded, with MAG_ROUND_EN) sqrt of x^2+y^2[+z^2].
// Latency 2W+2 cycles from accept to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
module vec_mag_iter #(
    parameter int W  = 8,
    parameter int CH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [W-1:0] in_z,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W:0]   out_mag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int S  = 2 * W + 2;
    localparam int RW = W + 2;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        SUM,
        SQRT,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CH-1:0][W-1:0]     comp_in;
    logic [CH-1:0][W-1:0]     mplr_q, mplr_d;
    logic [CH-1:0][2*W-1:0]   mcand_q, mcand_d;
    logic [CH-1:0][2*W-1:0]   acc_q, acc_d;
    logic [S-1:0]             rad_q, rad_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic [W-1:0]             root_q, root_d;
    logic [W:0]               mag_q, mag_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     vld_q, vld_d;
    logic                     busy_q, busy_d;

    logic [S-1:0]             sum;
    logic [RW+1:0]            win;
    logic [RW+1:0]            trial;
    logic                     fits;
    logic [RW-1:0]            rem_nx;
    logic [W:0]               root_nx;

    assign comp_in[0] = in_x;
    assign comp_in[1] = in_y;

    generate
        if (CH == 3) begin : g_z
            assign comp_in[CH-1] = in_z;
        end else begin : g_no_z
            logic unused_z;
            assign unused_z = ^in_z;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int c = 0; c < CH; c++) begin
            sum = sum + S'(acc_q[c]);
        end
    end

    // One root digit per cycle: bring down the next two radicand bits, try (root<<2)|1.
    assign win     = {rem_q, rad_q[S-1 -: 2]};
    assign trial   = {2'b00, root_q, 2'b01};
    assign fits    = (trial <= win);
    assign rem_nx  = fits ? RW'(win - trial) : RW'(win);
    assign root_nx = {root_q, fits};

    always_comb begin
        state_d = state_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int c = 0; c < CH; c++) begin
                        mplr_d[c]  = comp_in[c];
                        mcand_d[c] = {{W{1'b0}}, comp_in[c]};
                    end
                    acc_d   = '0;
                    rad_d   = '0;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = SQ;
                end
            end
            SQ: begin
                for (int c = 0; c < CH; c++) begin
                    if (mplr_q[c][0]) begin
                        acc_d[c] = acc_q[c] + mcand_q[c];
                    end
                    mcand_d[c] = mcand_q[c] << 1;
                    mplr_d[c]  = mplr_q[c] >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = SUM;
                end
            end
            SUM: begin
                rad_d   = sum;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = SQRT;
            end
            SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_nx;
                root_d = root_nx[W-1:0];
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(W)) begin
                    cnt_d = '0;
`ifdef MAG_ROUND_EN
                    // Final remainder S - r^2 exceeding r means sqrt(S) >= r + 0.5.
                    if (rem_nx > {1'b0, root_nx}) begin
                        mag_d = root_nx + {{W{1'b0}}, 1'b1};
                    end else begin
                        mag_d = root_nx;
                    end
`else
                    mag_d = root_nx;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vld_d  = (state_d == DONE);
    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mplr_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_mag   = mag_q;
    assign out_valid = vld_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vec_mag_iter.sv
// Directed bench for vec_mag_iter: three configurations (W=8/CH=2, W=8/CH=3, W=12/CH=2).
module tb_vec_mag_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] x, y, z;
    logic        vld, ordy;
    int          sel;

    logic [8:0]  mag_a, mag_b;
    logic [12:0] mag_c;
    logic        ir_a, ov_a, bz_a;
    logic        ir_b, ov_b, bz_b;
    logic        ir_c, ov_c, bz_c;

    logic [31:0] mag_s;
    logic        ir_s, ov_s, bz_s;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vec_mag_iter #(.W(8), .CH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_x(x[7:0]), .in_y(y[7:0]), .in_z(z[7:0]),
        .in_valid(vld && (sel == 0)), .in_ready(ir_a),
        .out_mag(mag_a), .out_valid(ov_a), .out_ready(ordy), .busy(bz_a)
    );

    vec_mag_iter #(.W(8), .CH(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_x(x[7:0]), .in_y(y[7:0]), .in_z(z[7:0]),
        .in_valid(vld && (sel == 1)), .in_ready(ir_b),
        .out_mag(mag_b), .out_valid(ov_b), .out_ready(ordy), .busy(bz_b)
    );

    vec_mag_iter #(.W(12), .CH(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_x(x), .in_y(y), .in_z(z),
        .in_valid(vld && (sel == 2)), .in_ready(ir_c),
        .out_mag(mag_c), .out_valid(ov_c), .out_ready(ordy), .busy(bz_c)
    );

    always_comb begin
        mag_s = 32'(mag_a);
        ir_s  = ir_a;
        ov_s  = ov_a;
        bz_s  = bz_a;
        if (sel == 1) begin
            mag_s = 32'(mag_b);
            ir_s  = ir_b;
            ov_s  = ov_b;
            bz_s  = bz_b;
        end else if (sel == 2) begin
            mag_s = 32'(mag_c);
            ir_s  = ir_c;
            ov_s  = ov_c;
            bz_s  = bz_c;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one vector, then verify latency, busy and magnitude; leaves the unit in DONE.
    task automatic run_vec(input int s, input int vx, input int vy, input int vz,
                           input int exp_mag, input int exp_lat, input string tag);
        int lat;
        int busy_low;
        sel = s;
        @(negedge clk);
        check_eq({tag, ".in_ready"}, 32'(ir_s), 32'd1);
        x   = 12'(vx);
        y   = 12'(vy);
        z   = 12'(vz);
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        x   = 12'hfff;
        y   = 12'h5a5;
        z   = 12'hfff;
        lat      = 0;
        busy_low = 0;
        while (!ov_s && lat < 100) begin
            if (!bz_s || ir_s) busy_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".busy"}, 32'(busy_low), 32'd0);
        check_eq({tag, ".mag"}, mag_s, 32'(exp_mag));
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
        check_eq({tag, ".out_valid_drop"}, 32'(ov_s), 32'd0);
        check_eq({tag, ".in_ready_back"}, 32'(ir_s), 32'd1);
    endtask

    initial begin
        int bad;
        int held;
        int exp_ff;
        int exp_11;
`ifdef MAG_ROUND_EN
        exp_ff = 361;
`else
        exp_ff = 360;
`endif
        exp_11 = 1;

        rst_n = 1'b0;
        vld   = 1'b0;
        ordy  = 1'b0;
        sel   = 0;
        x     = '0;
        y     = '0;
        z     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.mag", mag_s, 32'd0);
        check_eq("rst.out_valid", 32'(ov_s), 32'd0);
        check_eq("rst.busy", 32'(bz_s), 32'd0);
        check_eq("rst.in_ready", 32'(ir_s), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(0, 3, 4, 0, 5, 18, "v34");
        consume("v34");

        // Hold the result while new operands are offered.
        run_vec(0, 255, 255, 0, exp_ff, 18, "vff");
        held = int'(mag_s);
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vld = 1'b1;
            x   = 12'd1;
            y   = 12'd1;
            @(posedge clk);
            #1;
            if (int'(mag_s) != held || ir_s || !ov_s) bad++;
        end
        check_eq("bp.stable", 32'(bad), 32'd0);
        @(negedge clk);
        vld = 1'b0;
        consume("bp");

        run_vec(1, 2, 3, 6, 7, 18, "v236");
        consume("v236");
        run_vec(1, 0, 0, 0, 0, 18, "v000");
        consume("v000");

        // Abort mid-root; previous result (non-zero) must be wiped.
        sel = 0;
        run_vec(0, 1, 1, 0, exp_11, 18, "v11");
        consume("v11");
        @(negedge clk);
        x   = 12'd5;
        y   = 12'd12;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort.busy_before", 32'(bz_s), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort.out_valid", 32'(ov_s), 32'd0);
        check_eq("abort.mag", mag_s, 32'd0);
        check_eq("abort.in_ready", 32'(ir_s), 32'd1);
        check_eq("abort.busy", 32'(bz_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0, 6, 8, 0, 10, 18, "v68");
        consume("v68");

        run_vec(2, 4095, 0, 0, 4095, 26, "w12a");
        consume("w12a");
        run_vec(2, 4095, 4095, 0, 5791, 26, "w12b");
        consume("w12b");

        // out_ready already high when DONE is entered: consumed on the following edge.
        @(negedge clk);
        ordy = 1'b1;
        run_vec(0, 3, 4, 0, 5, 18, "early");
        @(posedge clk);
        #1;
        check_eq("early.out_valid_drop", 32'(ov_s), 32'd0);
        check_eq("early.in_ready_back", 32'(ir_s), 32'd1);
        ordy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
